// File: rtl/gem_link_pkg.sv
// Shared definitions for the GEM trigger fiber link: K-codes, the link reset
// word, slot charisk patterns and the receive framer state encoding.
package gem_link_pkg;

    localparam logic [7:0]  K_BC = 8'hBC;
    localparam logic [7:0]  K_F7 = 8'hF7;
    localparam logic [7:0]  K_FB = 8'hFB;
    localparam logic [7:0]  K_FD = 8'hFD;
    localparam logic [7:0]  K_FC = 8'hFC;

    localparam logic [31:0] RESET_WORD = 32'h50BC50BC;
    localparam logic [3:0]  RESET_ISK  = 4'b0101;
    localparam logic [3:0]  ISK_A      = 4'b0000;
    localparam logic [3:0]  ISK_B      = 4'b0001;

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} link_state_t;
    typedef enum logic [1:0] {W_ILLEGAL, W_A, W_B, W_RESET} word_class_t;

    function automatic logic is_sep(input logic [7:0] k);
        return k inside {K_BC, K_F7, K_FB, K_FD, K_FC};
    endfunction

endpackage

// File: rtl/gem_bx_seq_check.sv
// Maps bunch separator K-codes to a 2-bit index and checks that consecutive
// separators follow the BC, F7, FB, FD rotation (FC takes a slot unchecked).
module gem_bx_seq_check
    import gem_link_pkg::*;
(
    input  logic       TRG_CLK80,
    input  logic       TRG_RST_N,
    input  logic       restart,
    input  logic       sep_vld,
    input  logic [7:0] sep,
    output logic [1:0] sep_idx,
    output logic       sep_is_fc,
    output logic       seq_err
);

    logic [1:0] exp_idx_q;
    logic       armed_q;

    always_comb begin
        sep_is_fc = (sep == K_FC);
        case (sep)
            K_BC:    sep_idx = 2'd0;
            K_F7:    sep_idx = 2'd1;
            K_FB:    sep_idx = 2'd2;
            default: sep_idx = 2'd3;
        endcase
        seq_err = sep_vld && armed_q && !sep_is_fc && (sep_idx != exp_idx_q);
    end

    // A mismatch resyncs to the received index, so one glitch costs one error.
    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            exp_idx_q <= 2'd0;
            armed_q   <= 1'b0;
        end else if (restart) begin
            armed_q   <= 1'b0;
        end else if (sep_vld) begin
            if (sep_is_fc) begin
                exp_idx_q <= exp_idx_q + 2'd1;
            end else begin
                exp_idx_q <= sep_idx + 2'd1;
                armed_q   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gem_fiber_in.sv
// Receive framer for the GEM trigger fiber: locks onto the A/B word pairing,
// rebuilds the 56-bit cluster word and reports link resets and errors.
module gem_fiber_in
    import gem_link_pkg::*;
#(
    parameter int LOCK_FRAMES   = 8,
    parameter int UNLOCK_FRAMES = 4
) (
    input  logic        TRG_CLK80,
    input  logic        TRG_RST_N,
    input  logic [31:0] RX_DATA,
    input  logic [3:0]  RX_ISK,
    input  logic        RX_VALID,
    input  logic        ERR_CNT_CLR,
    output logic [55:0] GEM_DATA,
    output logic        GEM_OVERFLOW,
    output logic        DATA_VALID,
    output logic [1:0]  BX_SEQ,
    output logic        LOCKED,
    output logic        RST_SEEN,
    output logic        SEQ_ERR,
    output logic        FRAME_ERR,
    output logic [15:0] ERR_CNT
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_FRAMES);

    word_class_t cls;
    link_state_t state_q, state_d;
    logic        expect_b_q, expect_b_d;
    logic        a_ok_q;
    logic [31:0] a_hold_q;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [7:0]  bad_cnt_q, bad_cnt_d;
    logic        frame_a, frame_b, struct_good, frame_good, frame_bad, slot_bad;
    logic        dv_c, frame_err_c, restart;
    logic        seq_err, sep_is_fc;
    logic [1:0]  sep_idx;

    logic [55:0] gem_data_p1;
    logic        overflow_p1, dv_p1, rst_seen_p1, seq_err_p1, frame_err_p1;
    logic [1:0]  bx_seq_p1;
    logic [15:0] err_cnt_p1;

    always_comb begin
        cls = W_ILLEGAL;
        if (RX_VALID) begin
            if (RX_DATA == RESET_WORD && RX_ISK == RESET_ISK)
                cls = W_RESET;
            else if (RX_ISK == ISK_B && is_sep(RX_DATA[7:0]))
                cls = W_B;
            else if (RX_ISK == ISK_A)
                cls = W_A;
        end
    end

    assign frame_a     = (state_q != ST_HUNT) && !expect_b_q;
    assign frame_b     = (state_q != ST_HUNT) && expect_b_q;
    assign struct_good = frame_b && a_ok_q && (cls == W_B);
    assign frame_good  = struct_good && !seq_err;
    assign frame_bad   = frame_b && !frame_good;
    assign slot_bad    = (frame_a && cls != W_A) || (frame_b && !struct_good);
    assign restart     = (state_q == ST_HUNT) || (cls == W_RESET);

    gem_bx_seq_check u_seq (
        .TRG_CLK80 (TRG_CLK80),
        .TRG_RST_N (TRG_RST_N),
        .restart   (restart),
        .sep_vld   (struct_good),
        .sep       (RX_DATA[7:0]),
        .sep_idx   (sep_idx),
        .sep_is_fc (sep_is_fc),
        .seq_err   (seq_err)
    );

    // Once framed the phase free-runs; only HUNT derives it from the data.
    always_comb begin
        state_d     = state_q;
        expect_b_d  = !expect_b_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        dv_c        = 1'b0;
        frame_err_c = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (cls == W_B) begin
                    state_d    = ST_VERIFY;
                    expect_b_d = 1'b0;
                    good_cnt_d = 8'd0;
                end
            end
            ST_VERIFY: begin
                if (slot_bad) begin
                    state_d = ST_HUNT;
                end else if (frame_good) begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_q + 8'd1 == LOCK_N) begin
                        state_d   = ST_LOCKED;
                        bad_cnt_d = 8'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame_bad) begin
                    frame_err_c = 1'b1;
                    bad_cnt_d   = bad_cnt_q + 8'd1;
                    if (bad_cnt_q + 8'd1 == UNLOCK_N)
                        state_d = ST_HUNT;
                end else if (frame_good) begin
                    dv_c      = 1'b1;
                    bad_cnt_d = 8'd0;
                end
            end
            default: state_d = ST_HUNT;
        endcase
        if (cls == W_RESET) begin
            state_d     = ST_HUNT;
            bad_cnt_d   = bad_cnt_q;
            dv_c        = 1'b0;
            frame_err_c = 1'b0;
        end
    end

    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            state_q    <= ST_HUNT;
            expect_b_q <= 1'b0;
            good_cnt_q <= 8'd0;
            bad_cnt_q  <= 8'd0;
            a_ok_q     <= 1'b0;
            a_hold_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            expect_b_q <= expect_b_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            if (frame_a) begin
                a_ok_q <= (cls == W_A);
                if (cls == W_A)
                    a_hold_q <= RX_DATA;
            end
        end
    end

    // Output stage: everything below reflects the word of the previous cycle.
    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            gem_data_p1  <= 56'd0;
            overflow_p1  <= 1'b0;
            bx_seq_p1    <= 2'd0;
            dv_p1        <= 1'b0;
            rst_seen_p1  <= 1'b0;
            seq_err_p1   <= 1'b0;
            frame_err_p1 <= 1'b0;
        end else begin
            dv_p1        <= dv_c;
            rst_seen_p1  <= (cls == W_RESET);
            seq_err_p1   <= seq_err;
            frame_err_p1 <= frame_err_c;
            if (struct_good) begin
                gem_data_p1 <= {a_hold_q, RX_DATA[31:8]};
                overflow_p1 <= sep_is_fc;
                if (!sep_is_fc)
                    bx_seq_p1 <= sep_idx;
            end
        end
    end

    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N)
            err_cnt_p1 <= 16'd0;
        else if (ERR_CNT_CLR)
            err_cnt_p1 <= 16'd0;
        else if (frame_err_c && err_cnt_p1 != 16'hFFFF)
            err_cnt_p1 <= err_cnt_p1 + 16'd1;
    end

    assign GEM_DATA     = gem_data_p1;
    assign GEM_OVERFLOW = overflow_p1;
    assign DATA_VALID   = dv_p1;
    assign BX_SEQ       = bx_seq_p1;
    assign LOCKED       = (state_q == ST_LOCKED);
    assign RST_SEEN     = rst_seen_p1;
    assign SEQ_ERR      = seq_err_p1;
    assign FRAME_ERR    = frame_err_p1;
    assign ERR_CNT      = err_cnt_p1;

endmodule

// File: tb/tb_gem_fiber_in.sv
// Scoreboard bench for gem_fiber_in: drives framed word streams and checks
// payload, lock behaviour, error pulses and the error counter.
module tb_gem_fiber_in;
    import gem_link_pkg::*;

    logic        TRG_CLK80 = 1'b0;
    logic        TRG_RST_N;
    logic [31:0] RX_DATA;
    logic [3:0]  RX_ISK;
    logic        RX_VALID;
    logic        ERR_CNT_CLR;
    logic [55:0] GEM_DATA;
    logic        GEM_OVERFLOW;
    logic        DATA_VALID;
    logic [1:0]  BX_SEQ;
    logic        LOCKED;
    logic        RST_SEEN;
    logic        SEQ_ERR;
    logic        FRAME_ERR;
    logic [15:0] ERR_CNT;

    gem_fiber_in #(.LOCK_FRAMES(8), .UNLOCK_FRAMES(4)) dut (
        .TRG_CLK80    (TRG_CLK80),
        .TRG_RST_N    (TRG_RST_N),
        .RX_DATA      (RX_DATA),
        .RX_ISK       (RX_ISK),
        .RX_VALID     (RX_VALID),
        .ERR_CNT_CLR  (ERR_CNT_CLR),
        .GEM_DATA     (GEM_DATA),
        .GEM_OVERFLOW (GEM_OVERFLOW),
        .DATA_VALID   (DATA_VALID),
        .BX_SEQ       (BX_SEQ),
        .LOCKED       (LOCKED),
        .RST_SEEN     (RST_SEEN),
        .SEQ_ERR      (SEQ_ERR),
        .FRAME_ERR    (FRAME_ERR),
        .ERR_CNT      (ERR_CNT)
    );

    always #5 TRG_CLK80 = ~TRG_CLK80;

    typedef struct packed {
        logic [55:0] data;
        logic        ovf;
        logic [1:0]  bx;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         seq_err_pulses = 0;
    int         frame_err_pulses = 0;
    int         rst_seen_cycles = 0;
    int         rot = 0;
    logic [1:0] bx_model = 2'd0;
    logic [7:0] seps [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] bench_idx(input logic [7:0] k);
        case (k)
            K_BC:    return 2'd0;
            K_F7:    return 2'd1;
            K_FB:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    always @(negedge TRG_CLK80) begin
        exp_t e;
        if (TRG_RST_N) begin
            if (DATA_VALID) begin
                if (sb_q.size() == 0) begin
                    check("dv_unexpected", 64'(DATA_VALID), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("gem_data", 64'(GEM_DATA), 64'(e.data));
                    check("gem_overflow", 64'(GEM_OVERFLOW), 64'(e.ovf));
                    check("bx_seq", 64'(BX_SEQ), 64'(e.bx));
                end
            end
            if (SEQ_ERR)   seq_err_pulses++;
            if (FRAME_ERR) frame_err_pulses++;
            if (RST_SEEN)  rst_seen_cycles++;
        end
    end

    task automatic drive(input logic [31:0] d, input logic [3:0] k);
        @(negedge TRG_CLK80);
        RX_DATA  = d;
        RX_ISK   = k;
        RX_VALID = 1'b1;
        @(posedge TRG_CLK80);
        #1;
    endtask

    task automatic frame(input logic [31:0] a, input logic [23:0] b, input logic [7:0] sep, input bit push);
        logic [1:0] idx;
        exp_t       e;
        idx = bench_idx(sep);
        if (push) begin
            e.data = {a, b};
            e.ovf  = (sep == K_FC);
            e.bx   = (sep == K_FC) ? bx_model : idx;
            sb_q.push_back(e);
        end
        if (sep != K_FC) bx_model = idx;
        drive(a, ISK_A);
        drive({b, sep}, ISK_B);
    endtask

    task automatic next_frame(input bit push);
        frame($urandom, 24'($urandom), seps[rot % 4], push);
        rot++;
    endtask

    // B slot carries an ordinary data charisk, so the frame is structurally bad.
    task automatic bad_frame();
        drive($urandom, ISK_A);
        drive({24'($urandom), K_BC}, ISK_A);
    endtask

    task automatic preamble();
        drive({24'h0, K_FD}, ISK_B);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        seps = '{K_BC, K_F7, K_FB, K_FD};
        TRG_RST_N = 1'b0; RX_DATA = 32'd0; RX_ISK = 4'd0; RX_VALID = 1'b0; ERR_CNT_CLR = 1'b0;
        repeat (3) @(posedge TRG_CLK80);
        #1;
        check("rst_outputs", 64'({GEM_DATA, GEM_OVERFLOW, DATA_VALID, BX_SEQ, LOCKED, RST_SEEN, SEQ_ERR, FRAME_ERR}), 64'd0);
        check("rst_err_cnt", 64'(ERR_CNT), 64'd0);
        @(negedge TRG_CLK80);
        TRG_RST_N = 1'b1;

        // Lock acquisition
        preamble();
        for (int i = 1; i <= 10; i++) begin
            next_frame(i >= 9);
            if (i == 7) check("lock_not_yet", 64'(LOCKED), 64'd0);
            if (i == 8) begin
                check("lock_after_8", 64'(LOCKED), 64'd1);
                check("no_dv_lock_frame", 64'(DATA_VALID), 64'd0);
            end
            if (i == 9) check("dv_frame9", 64'(DATA_VALID), 64'd1);
        end

        // Overflow separator takes a rotation slot and leaves BX_SEQ alone
        for (int i = 0; i < 3; i++) next_frame(1'b1);
        frame($urandom, 24'($urandom), K_FC, 1'b1);
        rot++;
        check("ovf_set", 64'(GEM_OVERFLOW), 64'd1);
        check("ovf_bx_hold", 64'(BX_SEQ), 64'd0);
        next_frame(1'b1);
        next_frame(1'b1);
        check("ovf_no_seq_err", 64'(seq_err_pulses), 64'd0);

        // Sequence error: BC then FB
        next_frame(1'b1);
        frame($urandom, 24'($urandom), K_FB, 1'b0);
        rot = 19;
        check("seq_err_pulse", 64'(SEQ_ERR), 64'd1);
        check("seq_frame_err", 64'(FRAME_ERR), 64'd1);
        check("seq_err_cnt", 64'(ERR_CNT), 64'd1);
        check("seq_still_locked", 64'(LOCKED), 64'd1);
        next_frame(1'b1);
        check("seq_resync_ok", 64'(SEQ_ERR), 64'd0);

        // Three bad frames then a good one keep lock; four in a row drop it
        for (int i = 0; i < 3; i++) bad_frame();
        check("bad3_locked", 64'(LOCKED), 64'd1);
        check("bad3_err_cnt", 64'(ERR_CNT), 64'd4);
        next_frame(1'b1);
        for (int i = 1; i <= 4; i++) begin
            bad_frame();
            if (i == 3) check("bad4_pre_locked", 64'(LOCKED), 64'd1);
        end
        check("bad4_unlocked", 64'(LOCKED), 64'd0);
        check("bad4_frame_err", 64'(FRAME_ERR), 64'd1);
        check("bad4_err_cnt", 64'(ERR_CNT), 64'd8);

        // Relock, then link reset words
        preamble();
        for (int i = 0; i < 8; i++) next_frame(1'b0);
        check("relock", 64'(LOCKED), 64'd1);
        for (int i = 1; i <= 3; i++) begin
            drive(RESET_WORD, RESET_ISK);
            check("rst_seen_high", 64'(RST_SEEN), 64'd1);
            check("rst_word_unlocked", 64'(LOCKED), 64'd0);
        end
        preamble();
        check("rst_seen_low", 64'(RST_SEEN), 64'd0);
        check("rst_err_cnt_kept", 64'(ERR_CNT), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            next_frame(1'b0);
            if (i == 7) check("rst_relock_not_yet", 64'(LOCKED), 64'd0);
        end
        check("rst_relock", 64'(LOCKED), 64'd1);
        next_frame(1'b1);

        // Error counter saturation and clear priority
        force dut.err_cnt_p1 = 16'hFFFF;
        #1;
        release dut.err_cnt_p1;
        check("cnt_injected", 64'(ERR_CNT), 64'hFFFF);
        bad_frame();
        check("cnt_sat_frame_err", 64'(FRAME_ERR), 64'd1);
        check("cnt_saturated", 64'(ERR_CNT), 64'hFFFF);
        drive($urandom, ISK_A);
        @(negedge TRG_CLK80);
        RX_DATA = {24'($urandom), K_BC};
        RX_ISK = ISK_A;
        ERR_CNT_CLR = 1'b1;
        @(posedge TRG_CLK80);
        #1;
        ERR_CNT_CLR = 1'b0;
        check("cnt_clr_frame_err", 64'(FRAME_ERR), 64'd1);
        check("cnt_clr_priority", 64'(ERR_CNT), 64'd0);
        next_frame(1'b1);
        check("cnt_clr_locked", 64'(LOCKED), 64'd1);

        // Asynchronous reset in the middle of a frame
        drive($urandom, ISK_A);
        @(negedge TRG_CLK80);
        TRG_RST_N = 1'b0;
        #1;
        check("async_rst_outputs", 64'({GEM_DATA, GEM_OVERFLOW, DATA_VALID, BX_SEQ, LOCKED, RST_SEEN, SEQ_ERR, FRAME_ERR}), 64'd0);
        @(negedge TRG_CLK80);
        TRG_RST_N = 1'b1;
        RX_VALID = 1'b0;
        repeat (2) @(negedge TRG_CLK80);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("seq_err_total", 64'(seq_err_pulses), 64'd1);
        check("frame_err_total", 64'(frame_err_pulses), 64'd10);
        check("rst_seen_total", 64'(rst_seen_cycles), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
